// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered MIPS ID stage: decode, load-use hazard, flush, J resolve
// Optional DECODE_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module id_stage_pipe #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int ALUCODE_W = 5,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 if_valid,
   input  logic [31:0]          if_instr,
   input  logic [DATA_W-1:0]    if_pc4,
   input  logic                 ex_flush,
   output logic                 stall_o,
   output logic                 jump_o,
   output logic [DATA_W-1:0]    jump_target,
   output logic                 ex_valid,
   output logic                 ex_MemtoReg,
   output logic                 ex_RegWrite,
   output logic                 ex_MemWrite,
   output logic                 ex_MemRead,
   output logic                 ex_ALUSrcA,
   output logic                 ex_ALUSrcB,
   output logic                 ex_RegDst,
   output logic                 ex_JR,
   output logic [ALUCODE_W-1:0] ex_ALUCode,
   output logic [REG_AW-1:0]    ex_rs,
   output logic [REG_AW-1:0]    ex_rt,
   output logic [REG_AW-1:0]    ex_rd,
   output logic [4:0]           ex_shamt,
   output logic [DATA_W-1:0]    ex_imm,
   output logic [DATA_W-1:0]    ex_pc4
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
`endif
);

   localparam logic [5:0] OP_R = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08,
                          OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
                          OP_XORI = 6'h0e, OP_LW = 6'h23, OP_SW = 6'h2b;

   typedef struct packed {
      logic                 valid;
      logic                 m2r;
      logic                 rw;
      logic                 mw;
      logic                 mr;
      logic                 srca;
      logic                 srcb;
      logic                 rdst;
      logic                 jr;
      logic [ALUCODE_W-1:0] code;
      logic [REG_AW-1:0]    rs;
      logic [REG_AW-1:0]    rt;
      logic [REG_AW-1:0]    rd;
      logic [4:0]           shamt;
      logic [DATA_W-1:0]    imm;
      logic [DATA_W-1:0]    pc4;
   } idex_t;

   idex_t idex_d, idex_q;

   logic [5:0] op, funct;
   logic [4:0] rs_f, rt_f;
   logic d_ok, d_m2r, d_rw, d_mw, d_mr, d_srca, d_srcb, d_rdst, d_jr, d_isj, d_uses_rt, d_zext;
   logic [ALUCODE_W-1:0] d_code;
   logic hz, issue;

   assign op    = if_instr[31:26];
   assign rs_f  = if_instr[25:21];
   assign rt_f  = if_instr[20:16];
   assign funct = if_instr[5:0];

   always_comb begin
      d_ok = 1'b1; d_m2r = 1'b0; d_rw = 1'b0; d_mw = 1'b0; d_mr = 1'b0; d_srca = 1'b0;
      d_srcb = 1'b0; d_rdst = 1'b0; d_jr = 1'b0; d_isj = 1'b0; d_uses_rt = 1'b0; d_zext = 1'b0;
      d_code = ALUCODE_W'(0);
      case (op)
         OP_R: begin
            d_uses_rt = 1'b1;
            d_rdst    = 1'b1;
            d_rw      = 1'b1;
            case (funct)
               6'h20: d_code = ALUCODE_W'(0);
               6'h22: d_code = ALUCODE_W'(5);
               6'h24: d_code = ALUCODE_W'(1);
               6'h25: d_code = ALUCODE_W'(3);
               6'h26: d_code = ALUCODE_W'(2);
               6'h27: d_code = ALUCODE_W'(4);
               6'h2a: d_code = ALUCODE_W'(18);
               6'h2b: d_code = ALUCODE_W'(19);
               6'h00: begin d_code = ALUCODE_W'(15); d_srca = 1'b1; end
               6'h02: begin d_code = ALUCODE_W'(16); d_srca = 1'b1; end
               6'h03: begin d_code = ALUCODE_W'(17); d_srca = 1'b1; end
               6'h08: begin d_jr = 1'b1; d_rw = 1'b0; end
               default: d_ok = 1'b0;
            endcase
         end
         OP_ADDI:  begin d_rw = 1'b1; d_srcb = 1'b1; end
         OP_SLTI:  begin d_rw = 1'b1; d_srcb = 1'b1; d_code = ALUCODE_W'(18); end
         OP_SLTIU: begin d_rw = 1'b1; d_srcb = 1'b1; d_code = ALUCODE_W'(19); end
         OP_ANDI:  begin d_rw = 1'b1; d_srcb = 1'b1; d_zext = 1'b1; d_code = ALUCODE_W'(6); end
         OP_XORI:  begin d_rw = 1'b1; d_srcb = 1'b1; d_zext = 1'b1; d_code = ALUCODE_W'(7); end
         OP_ORI:   begin d_rw = 1'b1; d_srcb = 1'b1; d_zext = 1'b1; d_code = ALUCODE_W'(8); end
         OP_LW:    begin d_rw = 1'b1; d_srcb = 1'b1; d_mr = 1'b1; d_m2r = 1'b1; end
         OP_SW:    begin d_mw = 1'b1; d_srcb = 1'b1; d_uses_rt = 1'b1; end
         OP_BEQ:   begin d_code = ALUCODE_W'(9);  d_uses_rt = 1'b1; end
         OP_BNE:   begin d_code = ALUCODE_W'(10); d_uses_rt = 1'b1; end
         OP_BLEZ:  d_code = ALUCODE_W'(13);
         OP_BGTZ:  d_code = ALUCODE_W'(12);
         OP_REGIMM: begin
            case (rt_f)
               5'd1:    d_code = ALUCODE_W'(11);
               5'd0:    d_code = ALUCODE_W'(14);
               default: d_ok = 1'b0;
            endcase
         end
         OP_J:     begin d_isj = 1'b1; d_ok = 1'b0; end
         default:  d_ok = 1'b0;
      endcase
   end

   // Load-use: the load in EX cannot forward to an ID consumer in time.
   assign hz = idex_q.valid & idex_q.mr & (idex_q.rt != '0) & if_valid &
               ((idex_q.rt == REG_AW'(rs_f)) | (d_uses_rt & (idex_q.rt == REG_AW'(rt_f))));

   assign stall_o     = hz & ~ex_flush;
   assign jump_o      = if_valid & d_isj & ~hz & ~ex_flush;
   assign jump_target = {if_pc4[DATA_W-1:28], if_instr[25:0], 2'b00};
   assign issue       = if_valid & ~ex_flush & ~hz & d_ok;

   always_comb begin
      idex_d       = '0;
      idex_d.valid = issue;
      idex_d.m2r   = d_m2r;
      idex_d.rw    = issue & d_rw;
      idex_d.mw    = issue & d_mw;
      idex_d.mr    = issue & d_mr;
      idex_d.srca  = d_srca;
      idex_d.srcb  = d_srcb;
      idex_d.rdst  = d_rdst;
      idex_d.jr    = issue & d_jr;
      idex_d.code  = d_code;
      idex_d.rs    = REG_AW'(rs_f);
      idex_d.rt    = REG_AW'(rt_f);
      idex_d.rd    = REG_AW'(if_instr[15:11]);
      idex_d.shamt = if_instr[10:6];
      idex_d.imm   = d_zext ? {{(DATA_W-16){1'b0}}, if_instr[15:0]}
                            : {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
      idex_d.pc4   = if_pc4;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) idex_q <= '0;
      else        idex_q <= idex_d;
   end

   assign ex_valid    = idex_q.valid;
   assign ex_MemtoReg = idex_q.m2r;
   assign ex_RegWrite = idex_q.rw;
   assign ex_MemWrite = idex_q.mw;
   assign ex_MemRead  = idex_q.mr;
   assign ex_ALUSrcA  = idex_q.srca;
   assign ex_ALUSrcB  = idex_q.srcb;
   assign ex_RegDst   = idex_q.rdst;
   assign ex_JR       = idex_q.jr;
   assign ex_ALUCode  = idex_q.code;
   assign ex_rs       = idex_q.rs;
   assign ex_rt       = idex_q.rt;
   assign ex_rd       = idex_q.rd;
   assign ex_shamt    = idex_q.shamt;
   assign ex_imm      = idex_q.imm;
   assign ex_pc4      = idex_q.pc4;

`ifdef DECODE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_o && !(&stall_cnt_q))  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (ex_flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed vector table plus randomized model check for id_stage_pipe
module tb_id_stage_pipe;

   logic clk = 1'b0;
   logic rst_n, if_valid, ex_flush;
   logic [31:0] if_instr, if_pc4;
   logic stall_o, jump_o;
   logic [31:0] jump_target;
   logic ex_valid, ex_MemtoReg, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrcA, ex_ALUSrcB, ex_RegDst, ex_JR;
   logic [4:0] ex_ALUCode, ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [31:0] ex_imm, ex_pc4;
`ifdef DECODE_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   id_stage_pipe dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
      .ex_flush(ex_flush), .stall_o(stall_o), .jump_o(jump_o), .jump_target(jump_target),
      .ex_valid(ex_valid), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
      .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_ALUSrcA(ex_ALUSrcA),
      .ex_ALUSrcB(ex_ALUSrcB), .ex_RegDst(ex_RegDst), .ex_JR(ex_JR), .ex_ALUCode(ex_ALUCode),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_imm(ex_imm),
      .ex_pc4(ex_pc4)
`ifdef DECODE_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ctl order: valid, MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA, ALUSrcB, RegDst, JR
   logic [8:0] dut_ctl;
   assign dut_ctl = {ex_valid, ex_MemtoReg, ex_RegWrite, ex_MemWrite, ex_MemRead,
                     ex_ALUSrcA, ex_ALUSrcB, ex_RegDst, ex_JR};
   localparam logic [8:0] BUBBLE_MASK = 9'h171;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input bit full, input logic [8:0] ctl,
                           input logic [4:0] code, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm,
                           input logic [31:0] pc4);
      if (!full) begin
         chk({tag, " ctl"}, dut_ctl & BUBBLE_MASK, ctl & BUBBLE_MASK);
      end else begin
         chk({tag, " ctl"}, dut_ctl, ctl);
         chk({tag, " alucode"}, ex_ALUCode, code);
         chk({tag, " rs/rt/rd/shamt"}, {ex_rs, ex_rt, ex_rd, ex_shamt}, {rs, rt, rd, sh});
         chk({tag, " imm"}, ex_imm, imm);
         chk({tag, " pc4"}, ex_pc4, pc4);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          rst_n, iv, fl, stall, jump, full;
      logic [31:0] instr, pc4;
      logic [8:0]  ctl;
      logic [4:0]  code, rs, rt, rd, sh;
      logic [31:0] imm;
   } vec_t;

   vec_t vt[18];

   function automatic vec_t mk(bit r, bit iv, bit fl, logic [31:0] ins, logic [31:0] pc4, bit st, bit jp,
                               bit full, logic [8:0] ctl, logic [4:0] code, logic [4:0] rs,
                               logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [31:0] imm);
      vec_t v;
      v.rst_n = r; v.iv = iv; v.fl = fl; v.instr = ins; v.pc4 = pc4; v.stall = st; v.jump = jp;
      v.full = full; v.ctl = ctl; v.code = code; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh; v.imm = imm;
      return v;
   endfunction

   // ---------------- reference model ----------------
   localparam int C_R = 0, C_SH = 1, C_JR = 2, C_IMM = 3, C_LOGI = 4, C_LD = 5, C_ST = 6,
                  C_BRT = 7, C_BR = 8, C_J = 9;
   typedef struct { int op; int fn; int rtsel; int code; int cls; } itab_t;
   itab_t itab[27];

   typedef struct {
      bit         valid, m2r, rw, mw, mr, srca, srcb, rdst, jr, isj, uses_rt;
      logic [4:0] code;
      logic [31:0] imm;
   } dec_t;

   function automatic itab_t ent(int op, int fn, int rtsel, int code, int cls);
      itab_t e;
      e.op = op; e.fn = fn; e.rtsel = rtsel; e.code = code; e.cls = cls;
      return e;
   endfunction

   function automatic dec_t ref_dec(logic [31:0] ins);
      dec_t d;
      int cls = -1;
      int code = 0;
      for (int k = 0; k < 27; k++) begin
         if (itab[k].op == int'(ins[31:26]) && (itab[k].fn < 0 || itab[k].fn == int'(ins[5:0])) &&
             (itab[k].rtsel < 0 || itab[k].rtsel == int'(ins[20:16]))) begin
            cls = itab[k].cls;
            code = itab[k].code;
         end
      end
      d.valid   = (cls >= 0) && (cls != C_J);
      d.isj     = (cls == C_J);
      d.rw      = cls inside {C_R, C_SH, C_IMM, C_LOGI, C_LD};
      d.mw      = (cls == C_ST);
      d.mr      = (cls == C_LD);
      d.m2r     = (cls == C_LD);
      d.srca    = (cls == C_SH);
      d.srcb    = cls inside {C_IMM, C_LOGI, C_LD, C_ST};
      d.rdst    = cls inside {C_R, C_SH, C_JR};
      d.jr      = (cls == C_JR);
      d.uses_rt = (ins[31:26] == 6'h00) || cls inside {C_ST, C_BRT};
      d.code    = 5'(code);
      d.imm     = (cls == C_LOGI) ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
      return d;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] ins;
      itab_t e;
      ins = $urandom;
      if ($urandom_range(0, 19) == 0) return ins;
      e = itab[$urandom_range(0, 26)];
      ins[31:26] = 6'(e.op);
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      if (e.fn >= 0) ins[5:0] = 6'(e.fn);
      if (e.rtsel >= 0) ins[20:16] = 5'(e.rtsel);
      return ins;
   endfunction

   typedef struct {
      logic [8:0]  ctl;
      logic [4:0]  code, rs, rt, rd, sh;
      logic [31:0] imm, pc4;
   } ex_t;

   initial begin
      ex_t  cur;
      dec_t d;
      bit   hz, exp_stall, exp_jump, issue, held, full;

      itab[0]  = ent(0, 'h20, -1, 0, C_R);   itab[1]  = ent(0, 'h22, -1, 5, C_R);
      itab[2]  = ent(0, 'h24, -1, 1, C_R);   itab[3]  = ent(0, 'h25, -1, 3, C_R);
      itab[4]  = ent(0, 'h26, -1, 2, C_R);   itab[5]  = ent(0, 'h27, -1, 4, C_R);
      itab[6]  = ent(0, 'h2a, -1, 18, C_R);  itab[7]  = ent(0, 'h2b, -1, 19, C_R);
      itab[8]  = ent(0, 'h00, -1, 15, C_SH); itab[9]  = ent(0, 'h02, -1, 16, C_SH);
      itab[10] = ent(0, 'h03, -1, 17, C_SH); itab[11] = ent(0, 'h08, -1, 0, C_JR);
      itab[12] = ent('h08, -1, -1, 0, C_IMM);  itab[13] = ent('h0a, -1, -1, 18, C_IMM);
      itab[14] = ent('h0b, -1, -1, 19, C_IMM); itab[15] = ent('h0c, -1, -1, 6, C_LOGI);
      itab[16] = ent('h0d, -1, -1, 8, C_LOGI); itab[17] = ent('h0e, -1, -1, 7, C_LOGI);
      itab[18] = ent('h23, -1, -1, 0, C_LD);   itab[19] = ent('h2b, -1, -1, 0, C_ST);
      itab[20] = ent('h04, -1, -1, 9, C_BRT);  itab[21] = ent('h05, -1, -1, 10, C_BRT);
      itab[22] = ent('h06, -1, -1, 13, C_BR);  itab[23] = ent('h07, -1, -1, 12, C_BR);
      itab[24] = ent('h01, -1, 1, 11, C_BR);   itab[25] = ent('h01, -1, 0, 14, C_BR);
      itab[26] = ent('h02, -1, -1, 0, C_J);

      //           rst iv fl instr         pc4           st jp full ctl     code rs  rt  rd  sh  imm
      vt[0]  = mk(0, 1, 0, 32'h01095022, 32'h00000100, 0, 0, 1, 9'h000, 0,  0,  0,  0,  0,  32'h0);
      vt[1]  = mk(1, 1, 0, 32'h01095022, 32'h00400004, 0, 0, 1, 9'h142, 5,  8,  9,  10, 0,  32'h00005022);
      vt[2]  = mk(1, 1, 0, 32'hac0b000c, 32'h00400008, 0, 0, 1, 9'h124, 0,  0,  11, 0,  0,  32'h0000000c);
      vt[3]  = mk(1, 1, 0, 32'h2008fffe, 32'h0040000c, 0, 0, 1, 9'h144, 0,  0,  8,  31, 31, 32'hfffffffe);
      vt[4]  = mk(1, 1, 0, 32'h8d2c0008, 32'h00400010, 0, 0, 1, 9'h1d4, 0,  9,  12, 0,  0,  32'h8);
      vt[5]  = mk(1, 1, 0, 32'h000c4080, 32'h00400014, 1, 0, 0, 9'h000, 0,  0,  0,  0,  0,  32'h0);
      vt[6]  = mk(1, 1, 0, 32'h000c4080, 32'h00400014, 0, 0, 1, 9'h14a, 15, 0,  12, 8,  2,  32'h4080);
      vt[7]  = mk(1, 1, 0, 32'h0800000b, 32'h00000004, 0, 1, 0, 9'h000, 0,  0,  0,  0,  0,  32'h0);
      vt[8]  = mk(1, 1, 1, 32'h0800000b, 32'h00000004, 0, 0, 0, 9'h000, 0,  0,  0,  0,  0,  32'h0);
      vt[9]  = mk(1, 1, 1, 32'h1000fff4, 32'h00400020, 0, 0, 0, 9'h000, 0,  0,  0,  0,  0,  32'h0);
      vt[10] = mk(1, 1, 0, 32'h8d2c0008, 32'h00400024, 0, 0, 1, 9'h1d4, 0,  9,  12, 0,  0,  32'h8);
      vt[11] = mk(1, 1, 1, 32'h000c4080, 32'h00400028, 0, 0, 0, 9'h000, 0,  0,  0,  0,  0,  32'h0);
      vt[12] = mk(1, 1, 0, 32'h8c000000, 32'h0040002c, 0, 0, 1, 9'h1d4, 0,  0,  0,  0,  0,  32'h0);
      vt[13] = mk(1, 1, 0, 32'h00000020, 32'h00400030, 0, 0, 1, 9'h142, 0,  0,  0,  0,  0,  32'h20);
      vt[14] = mk(1, 1, 0, 32'h3108ffff, 32'h00400034, 0, 0, 1, 9'h144, 6,  8,  8,  31, 31, 32'h0000ffff);
      vt[15] = mk(1, 0, 0, 32'h01095022, 32'h00400038, 0, 0, 0, 9'h000, 0,  0,  0,  0,  0,  32'h0);
      vt[16] = mk(1, 1, 0, 32'h03e00008, 32'h0040003c, 0, 0, 0, 9'h101, 0,  0,  0,  0,  0,  32'h0);
      vt[17] = mk(1, 1, 0, 32'hfc000000, 32'h00400040, 0, 0, 0, 9'h000, 0,  0,  0,  0,  0,  32'h0);

      rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc4 = '0; ex_flush = 1'b0;
      #1;
      for (int i = 0; i < 18; i++) begin
         string tag;
         logic [31:0] epc4, etgt;
         tag = $sformatf("vec%0d", i);
         rst_n = vt[i].rst_n; if_valid = vt[i].iv; ex_flush = vt[i].fl;
         if_instr = vt[i].instr; if_pc4 = vt[i].pc4;
         #2;
         if (i > 0) begin
            chk({tag, " stall"}, stall_o, vt[i].stall);
            chk({tag, " jump"}, jump_o, vt[i].jump);
            if (vt[i].jump) begin
               etgt = {vt[i].pc4[31:28], vt[i].instr[25:0], 2'b00};
               chk({tag, " target"}, jump_target, etgt);
            end
         end
         @(posedge clk); #1;
         epc4 = vt[i].rst_n ? vt[i].pc4 : 32'h0;
         chk_regs(tag, vt[i].full, vt[i].ctl, vt[i].code, vt[i].rs, vt[i].rt, vt[i].rd,
                  vt[i].sh, vt[i].imm, epc4);
      end

      // Randomized run: IF/ID holds its instruction while stalled, like the real front end.
      rst_n = 1'b0; if_valid = 1'b0; ex_flush = 1'b0;
      @(posedge clk); #1;
      cur = '{ctl: '0, code: '0, rs: '0, rt: '0, rd: '0, sh: '0, imm: '0, pc4: '0};
      held = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!held) begin
            if_instr = gen_instr();
            if_pc4   = $urandom;
            if_valid = ($urandom_range(0, 9) != 0);
         end
         ex_flush = ($urandom_range(0, 9) == 0);
         rst_n    = ($urandom_range(0, 99) != 0);
         d  = ref_dec(if_instr);
         hz = cur.ctl[8] && cur.ctl[4] && cur.rt != 0 && if_valid &&
              (cur.rt == if_instr[25:21] || (d.uses_rt && cur.rt == if_instr[20:16]));
         exp_stall = hz && !ex_flush;
         exp_jump  = if_valid && d.isj && !hz && !ex_flush;
         #2;
         chk("rnd stall", stall_o, exp_stall);
         chk("rnd jump", jump_o, exp_jump);
         chk("rnd target", jump_target, {if_pc4[31:28], if_instr[25:0], 2'b00});
         issue = if_valid && !ex_flush && !hz && d.valid;
         full  = 1'b1;
         if (!rst_n) begin
            cur = '{ctl: '0, code: '0, rs: '0, rt: '0, rd: '0, sh: '0, imm: '0, pc4: '0};
         end else if (issue) begin
            cur.ctl  = {1'b1, d.m2r, d.rw, d.mw, d.mr, d.srca, d.srcb, d.rdst, d.jr};
            cur.code = d.code; cur.rs = if_instr[25:21]; cur.rt = if_instr[20:16];
            cur.rd = if_instr[15:11]; cur.sh = if_instr[10:6]; cur.imm = d.imm; cur.pc4 = if_pc4;
         end else begin
            cur.ctl = '0;
            full = 1'b0;
         end
         @(posedge clk); #1;
         chk_regs("rnd", full, cur.ctl, cur.code, cur.rs, cur.rt, cur.rd, cur.sh, cur.imm, cur.pc4);
         held = exp_stall && rst_n;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
